// File: rtl/math_multiplier_shift_add_if.sv
// math_multiplier_shift_add_if: start/busy/done/valid handshake and operand/result bus for the shift-add MAC
// master: drives i_start and the three W-bit operands; observes busy/done/valid/ovf and the 2W-bit product
// slave:  the multiplier itself, which samples the operands and drives the results
interface math_multiplier_shift_add_if #(parameter int DATA_WIDTH = 16);
    logic                    i_start;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_valid;
    logic                    o_ovf;
    logic [DATA_WIDTH-1:0]   i_multiplicand;
    logic [DATA_WIDTH-1:0]   i_multiplier;
    logic [DATA_WIDTH-1:0]   i_addend;
    logic [2*DATA_WIDTH-1:0] o_product;
    modport master(
        output i_start, i_multiplicand, i_multiplier, i_addend,
        input  o_busy, o_done, o_valid, o_ovf, o_product
    );
    modport slave(
        input  i_start, i_multiplicand, i_multiplier, i_addend,
        output o_busy, o_done, o_valid, o_ovf, o_product
    );
endinterface

// File: rtl/math_multiplier_shift_add.sv
// math_multiplier_shift_add: sequential multiply-accumulate, product = multiplicand * multiplier + addend, one multiplier bit per clock
// i_clk   : clock
// i_rst_b : asynchronous active-low reset, aborts any operation without a done pulse
// bus     : slave side of math_multiplier_shift_add_if (i_start, operands in; busy/done/valid/ovf/product out)
// MATH_MULT_SHIFT_ADD_EARLY_TERM_EN: when defined, finish as soon as no set multiplier bits remain
module math_multiplier_shift_add #(
    parameter int DATA_WIDTH = 16
) (
    input logic                        i_clk,
    input logic                        i_rst_b,
    math_multiplier_shift_add_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state, state_nxt;
    logic [2*W-1:0]  r_mcand, r_prod, sum;
    logic [W-1:0]    r_mplier;
    logic [IW-1:0]   r_i;
    logic            last;
    // Never carries out of 2W bits: the largest result is 2^2W - 2^W.
    assign sum = r_prod + (r_mplier[0] ? r_mcand : '0);
`ifdef MATH_MULT_SHIFT_ADD_EARLY_TERM_EN
    assign last = (r_i == IW'(W - 1)) || ((r_mplier >> 1) == '0);
`else
    assign last = r_i == IW'(W - 1);
`endif
    assign bus.o_busy = state == RUN;
    always_comb begin
        state_nxt = bus.i_start ? RUN : (state == RUN && last) ? IDLE : state;
    end
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) state <= IDLE;
        else          state <= state_nxt;
    end
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_prod        <= '0;
            r_i           <= '0;
            bus.o_done    <= 1'b0;
            bus.o_valid   <= 1'b0;
            bus.o_ovf     <= 1'b0;
            bus.o_product <= '0;
        end else begin
            bus.o_done <= 1'b0;
            if (bus.i_start) begin
                // A start while busy simply reloads, silently dropping the old operation.
                r_mcand     <= {{W{1'b0}}, bus.i_multiplicand};
                r_mplier    <= bus.i_multiplier;
                r_prod      <= {{W{1'b0}}, bus.i_addend};
                r_i         <= '0;
                bus.o_valid <= 1'b0;
            end else if (state == RUN) begin
                r_prod   <= sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_i      <= r_i + IW'(1);
                if (last) begin
                    bus.o_product <= sum;
                    bus.o_ovf     <= |sum[2*W-1:W];
                    bus.o_done    <= 1'b1;
                    bus.o_valid   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/math_multiplier_shift_add.md
# math_multiplier_shift_add

Sequential shift-add multiply-accumulate unit computing `o_product = i_multiplicand * i_multiplier + i_addend`, one multiplier bit per clock. It is the inverse-direction companion of the sequential divider in the common math library, and uses the same start/busy/done/valid handshake. Typical use is reconstructing `dividend = quotient * divisor + remainder` to self-check divider results. It also serves as a low-area multiplier wherever throughput is not critical.

## Interface
- `DATA_WIDTH`, default 16: operand width W; the product is 2W bits.
- `i_clk`  in  1  clock.
- `i_rst_b`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start pulse; samples the operands.
- `o_busy`  out  1  operation in progress.
- `o_done`  out  1  one-cycle completion pulse.
- `o_valid`  out  1  `o_product` and `o_ovf` hold a completed result.
- `o_ovf`  out  1  result ≥ 2^W, i.e. the upper half of the product is nonzero.
- `i_multiplicand`  in  W  multiplicand (unsigned).
- `i_multiplier`  in  W  multiplier (unsigned); scanned LSB first.
- `i_addend`  in  W  accumulate term (unsigned), zero-extended.
- `o_product`  out  2W  result.

## Operation
- **Internal registers**
  - `r_mcand` [2W-1:0]: shifts left one bit per iteration.
  - `r_mplier` [W-1:0]: shifts right one bit per iteration.
  - `r_prod` [2W-1:0]: accumulator.
  - `r_i`: iteration counter, `$clog2(W)` bits.
- **States:** IDLE (`o_busy`=0) and RUN (`o_busy`=1).
- **Start, from any state:**
  - `r_mcand <= {W'0, i_multiplicand}`
  - `r_mplier <= i_multiplier`
  - `r_prod <= {W'0, i_addend}`
  - `r_i <= 0`, `o_busy <= 1`, `o_valid <= 0`
  - Go to RUN.
- **Start while busy:** aborts the current operation and restarts with the new operands. No `o_done` is issued for the aborted operation.
- **Each RUN iteration:**
  - If `r_mplier[0]`: `r_prod += r_mcand`. The sum is 2W bits and never carries out, because the maximum result is 2^2W − 2^W.
  - `r_mcand <<= 1`, `r_mplier >>= 1`, `r_i++`.
- **Final iteration** (`r_i == W-1`):
  - `o_product` = the post-add accumulator value.
  - `o_ovf` = OR of `o_product[2W-1:W]`.
  - `o_busy <= 0`, `o_done <= 1`, `o_valid <= 1`; return to IDLE.
- **Other outputs:**
  - `o_done` is cleared every cycle unless it is being set.
  - `o_valid`, `o_product` and `o_ovf` hold until the next `i_start`. `o_product` and `o_ovf` retain their old values while busy; only `o_valid` drops.
- **No error cases:** there are no illegal inputs. Zero operands produce `o_product = i_addend`.
- **Reset:** asynchronous, and takes effect at any time, including mid-operation. It aborts the operation with no `o_done`.
  - `o_busy`, `o_done`, `o_valid`, `o_ovf` = 0.
  - `o_product` = 0.
  - Internal registers = 0.

## Timing
- `i_start` is sampled at edge E0. Iterations occur at E1..EW, with the final iteration at EW.
- `o_done`/`o_valid` are high in the cycle following EW, so latency is W cycles.
- `o_busy` is high from after E0 through EW.
- Back-to-back operation: `i_start` may be asserted in the same cycle as `o_done`. The next result follows W cycles later, giving a throughput of one result per W cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`MATH_MULT_SHIFT_ADD_EARLY_TERM_EN` defined:** early termination is enabled.
  - The final iteration is the first one in which the post-shift `r_mplier` is 0, or in which `r_i == W-1`.
  - Latency n = max(1, msb_index(`i_multiplier`) + 1). A zero multiplier takes 1 cycle.
  - The result is identical to the undefined case.
- **`MATH_MULT_SHIFT_ADD_EARLY_TERM_EN` undefined:** latency is fixed at W cycles for all operands.

## Test plan
All scenarios use DATA_WIDTH=16.
1. Basic MAC: 1234 × 56 + 7 -> after 16 cycles (6 with EARLY_TERM_EN), `o_product`=0x00010DF7 (69111), `o_ovf`=1, `o_done` pulses once, `o_valid`=1.
2. Exact fit: 255 × 257 + 0 -> 0x0000FFFF, `o_ovf`=0.
3. Max operands: 0xFFFF × 0xFFFF + 0xFFFF -> 0xFFFF0000, `o_ovf`=1, latency 16 in both configurations.
4. Zero multiplier: 0xABCD × 0 + 42 -> 42, `o_ovf`=0, latency 16 (1 with EARLY_TERM_EN).
5. Restart mid-op: start 100 × 200 + 0, then start 3 × 5 + 1 at cycle 8 -> exactly one `o_done`, 16 cycles after the second start, with `o_product`=16; `o_valid` low in between.
6. Reset mid-op: assert `i_rst_b`=0 at cycle 5 of an operation -> all outputs 0 immediately, no `o_done`; a subsequent start of 7 × 9 + 2 yields 65.
